// File: rtl/cmp_search_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_search_ctrl_pkg
// Brief    : Shared state encoding and helpers for the comparator search ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_search_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int C_DEF_WIDTH = 4;

    // An honest search needs at most WIDTH+1 probes, so the counter must hold that.
    function automatic int calc_cntw(input int width);
        return $clog2(width + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_search_ctrl_next.sv
`default_nettype none
// ============================================================================
// Module   : cmp_search_next
// Brief    : Next-interval and midpoint calculation for one binary-search step.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_search_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] probe,
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    input  logic             gt,
    input  logic             lt,
    output logic [WIDTH:0]   next_lo,
    output logic [WIDTH:0]   next_hi,
    output logic [WIDTH-1:0] next_probe,
    output logic             exhausted
);

    localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]          w_probe_ext;
    logic signed [WIDTH+1:0] w_lo_s;
    logic signed [WIDTH+1:0] w_hi_s;

    assign w_probe_ext = {1'b0, probe};
    assign next_lo     = gt ? (w_probe_ext + c_one) : lo;
    assign next_hi     = lt ? (w_probe_ext - c_one) : hi;

    // lo only ever grows (up to 2^WIDTH), hi may drop to -1: extend each accordingly.
    assign w_lo_s    = $signed({1'b0, next_lo});
    assign w_hi_s    = $signed({next_hi[WIDTH], next_hi});
    assign exhausted = (w_lo_s > w_hi_s);

    assign next_probe = WIDTH'((next_lo + next_hi) >> 1);

endmodule
`default_nettype wire

// File: rtl/cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cmp_search_ctrl
// Brief    : Binary-search controller driving the probe of a magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_search_ctrl
    import cmp_search_ctrl_pkg::*;
#(
    parameter  int WIDTH = C_DEF_WIDTH,
    localparam int CNTW  = calc_cntw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [CNTW-1:0]  iter_cnt
);

    localparam logic [WIDTH:0]   c_lo_init    = '0;
    localparam logic [WIDTH:0]   c_hi_init    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] c_probe_init = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNTW-1:0]  c_iter_one   = {{(CNTW-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_result;
    logic [CNTW-1:0]  r_iter;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic             r_err;

    logic [WIDTH:0]   w_next_lo;
    logic [WIDTH:0]   w_next_hi;
    logic [WIDTH-1:0] w_next_probe;
    logic             w_exhausted;
    logic             w_flags_ok;

    cmp_search_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .probe      (r_probe),
        .lo         (r_lo),
        .hi         (r_hi),
        .gt         (gt),
        .lt         (lt),
        .next_lo    (w_next_lo),
        .next_hi    (w_next_hi),
        .next_probe (w_next_probe),
        .exhausted  (w_exhausted)
    );

    assign w_flags_ok = $onehot({gt, lt, eq});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_probe  <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_result <= '0;
            r_iter   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SEARCH;
                        r_busy   <= 1'b1;
                        r_lo     <= c_lo_init;
                        r_hi     <= c_hi_init;
                        r_probe  <= c_probe_init;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        r_iter   <= '0;
                    end
                end
                S_SEARCH: begin
                    // abort wins over whatever the comparator reports this cycle
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_iter <= r_iter + c_iter_one;
                        if (!w_flags_ok) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (eq) begin
                            r_result <= r_probe;
                            r_found  <= 1'b1;
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_lo <= w_next_lo;
                            r_hi <= w_next_hi;
                            if (w_exhausted) begin
                                r_err   <= 1'b1;
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_probe <= w_next_probe;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign probe    = r_probe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign found    = r_found;
    assign err      = r_err;
    assign result   = r_result;
    assign iter_cnt = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_search_ctrl
// Brief    : Directed scoreboard bench for cmp_search_ctrl with a comparator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_search_ctrl;
    import cmp_search_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNTW  = calc_cntw(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             gt, lt, eq;
    logic [WIDTH-1:0] probe;
    logic             busy, done, found, err;
    logic [WIDTH-1:0] result;
    logic [CNTW-1:0]  iter_cnt;

    logic [WIDTH-1:0] target;
    int               mode;

    typedef struct {
        bit found;
        bit err;
        int result;
        int iter;
    } exp_t;

    exp_t sb[$];
    int   pq[$];
    int   n_cmp;
    int   n_mis;

    cmp_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .gt       (gt),
        .lt       (lt),
        .eq       (eq),
        .probe    (probe),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .err      (err),
        .result   (result),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator: 0 honest, 1 lt stuck, 2 gt+lt, 3 no flags, 4 gt stuck
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        case (mode)
            0: begin
                gt = (target > probe);
                lt = (target < probe);
                eq = (target == probe);
            end
            1: lt = 1'b1;
            2: begin
                gt = 1'b1;
                lt = 1'b1;
            end
            4: gt = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected probes must already be in pq; the final outcome is pushed here.
    task automatic run_search(input string name, input int tgt, input int md, input bit mid_start,
                              input bit efound, input bit eerr, input int eres);
        exp_t e;
        int   cyc;
        int   exp_p;
        bit   seen;
        e.found  = efound;
        e.err    = eerr;
        e.result = eres;
        e.iter   = pq.size();
        sb.push_back(e);
        target = tgt[WIDTH-1:0];
        mode   = md;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            start = mid_start && (cyc == 1);
            if (busy) begin
                exp_p = (pq.size() != 0) ? pq.pop_front() : -1;
                check({name, " probe"}, 32'(probe), exp_p);
            end
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({name, " done_seen"}, 32'(seen), 1);
        check({name, " latency"}, cyc, e.iter);
        check({name, " found"}, 32'(found), 32'(e.found));
        check({name, " err"}, 32'(err), 32'(e.err));
        check({name, " result"}, 32'(result), e.result);
        check({name, " iter_cnt"}, 32'(iter_cnt), e.iter);
        check({name, " probes_left"}, pq.size(), 0);
        pq.delete();
        @(negedge clk);
        check({name, " done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_mis  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        target = '0;
        mode   = 0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst probe", 32'(probe), 0);
        check("rst iter", 32'(iter_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        pq = '{7, 11, 9, 10};
        run_search("t10", 10, 0, 1'b0, 1'b1, 1'b0, 10);
        pq = '{7, 11, 13, 14, 15};
        run_search("t15", 15, 0, 1'b0, 1'b1, 1'b0, 15);
        pq = '{7, 3, 1, 0};
        run_search("t0", 0, 0, 1'b0, 1'b1, 1'b0, 0);
        pq = '{7, 3, 1, 0};
        run_search("lt_stuck", 9, 1, 1'b0, 1'b0, 1'b1, 0);
        pq = '{7, 11, 13, 14, 15};
        run_search("gt_stuck", 3, 4, 1'b0, 1'b0, 1'b1, 0);
        pq = '{7};
        run_search("gt_lt", 6, 2, 1'b0, 1'b0, 1'b1, 0);
        pq = '{7};
        run_search("no_flag", 6, 3, 1'b0, 1'b0, 1'b1, 0);
        pq = '{7, 11, 9, 10};
        run_search("restart", 10, 0, 1'b1, 1'b1, 1'b0, 10);

        // abort while the second probe is presented
        target = 4'd12;
        mode   = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("abort probe1", 32'(probe), 7);
        @(negedge clk);
        check("abort probe2", 32'(probe), 11);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort found", 32'(found), 0);
        check("abort iter", 32'(iter_cnt), 1);
        repeat (3) begin
            @(negedge clk);
            check("abort no_done", 32'(done | busy), 0);
        end

        // asynchronous reset in the middle of a search
        target = 4'd10;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy), 0);
        check("arst probe", 32'(probe), 0);
        check("arst iter", 32'(iter_cnt), 0);
        check("arst flags", 32'({done, found, err}), 0);
        check("arst result", 32'(result), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        pq = '{7, 3, 5};
        run_search("t5", 5, 0, 1'b0, 1'b1, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
